// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, opcode values, IR capture pattern
// and the 1149.1 TMS transition table.
package jtag_pkg;

   typedef enum logic [3:0] {
      EX2_DR = 4'h0,
      EX1_DR = 4'h1,
      SH_DR  = 4'h2,
      PAU_DR = 4'h3,
      SEL_IR = 4'h4,
      UPD_DR = 4'h5,
      CAP_DR = 4'h6,
      SEL_DR = 4'h7,
      EX2_IR = 4'h8,
      EX1_IR = 4'h9,
      SH_IR  = 4'hA,
      PAU_IR = 4'hB,
      RTI    = 4'hC,
      UPD_IR = 4'hD,
      CAP_IR = 4'hE,
      TLR    = 4'hF
   } tap_state_t;

   localparam int unsigned OP_EXTEST = 0;
   localparam int unsigned OP_SAMPLE = 1;
   localparam int unsigned OP_IDCODE = 2;

   localparam logic [1:0] IR_CAPTURE = 2'b01;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      tap_state_t n;
      case (s)
         TLR:     n = tms ? TLR    : RTI;
         RTI:     n = tms ? SEL_DR : RTI;
         SEL_DR:  n = tms ? SEL_IR : CAP_DR;
         CAP_DR:  n = tms ? EX1_DR : SH_DR;
         SH_DR:   n = tms ? EX1_DR : SH_DR;
         EX1_DR:  n = tms ? UPD_DR : PAU_DR;
         PAU_DR:  n = tms ? EX2_DR : PAU_DR;
         EX2_DR:  n = tms ? UPD_DR : SH_DR;
         UPD_DR:  n = tms ? SEL_DR : RTI;
         SEL_IR:  n = tms ? TLR    : CAP_IR;
         CAP_IR:  n = tms ? EX1_IR : SH_IR;
         SH_IR:   n = tms ? EX1_IR : SH_IR;
         EX1_IR:  n = tms ? UPD_IR : PAU_IR;
         PAU_IR:  n = tms ? EX2_IR : PAU_IR;
         EX2_IR:  n = tms ? UPD_IR : SH_IR;
         UPD_IR:  n = tms ? SEL_DR : RTI;
         default: n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Board JTAG pins plus the boundary-scan chain hookup seen by the TAP.
interface jtag_tap_ctrl_if;
   import jtag_pkg::*;

   logic       TMS;
   logic       TDI;
   logic       TDO;
   logic       TDO_EN;
   logic       bsr_tdi;
   logic       bsr_tdo;
   logic       mode;
   logic       shift_dr;
   logic       clk_dr;
   logic       update_dr;
   tap_state_t tap_state;

   modport slave (
      input  TMS, TDI, bsr_tdo,
      output TDO, TDO_EN, bsr_tdi, mode, shift_dr, clk_dr, update_dr, tap_state
   );

   modport master (
      output TMS, TDI, bsr_tdo,
      input  TDO, TDO_EN, bsr_tdi, mode, shift_dr, clk_dr, update_dr, tap_state
   );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state register and TMS-driven next-state logic.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       ICLK,
   input  logic       RST,
   input  logic       tms_i,
   output tap_state_t state_o,
   output tap_state_t next_o
);

   tap_state_t state_q, state_d;

   always_ff @(posedge ICLK or posedge RST) begin
      if (RST) state_q <= TLR;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = tap_next(state_q, tms_i);
   end

   assign state_o = state_q;
   assign next_o  = state_d;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR, BYPASS, optional IDCODE register, TDO mux and BSR control decode.
// Define JTAG_IDCODE_EN to build the 32-bit IDCODE register and make IDCODE the reset instruction.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int          IR_W       = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic           ICLK,
   input  logic           RST,
   jtag_tap_ctrl_if.slave jtag
);

   localparam logic [IR_W-1:0] EXTEST = IR_W'(OP_EXTEST);
   localparam logic [IR_W-1:0] SAMPLE = IR_W'(OP_SAMPLE);
   localparam logic [IR_W-1:0] BYPASS = {IR_W{1'b1}};
   localparam logic [IR_W-1:0] IR_CAP = IR_W'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
   localparam logic [IR_W-1:0] IDCODE = IR_W'(OP_IDCODE);
   localparam logic [IR_W-1:0] IR_RST = IDCODE;
`else
   localparam logic [IR_W-1:0] IR_RST = BYPASS;
`endif

   tap_state_t      state, state_next;
   logic [IR_W-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d, ir_shift;
   logic            bypass_q, bypass_d;
   logic            bsr_sel, id_sel, id_lsb;

   jtag_tap_fsm u_fsm (
      .ICLK    (ICLK),
      .RST     (RST),
      .tms_i   (jtag.TMS),
      .state_o (state),
      .next_o  (state_next)
   );

   genvar gi;
   generate
      for (gi = 0; gi < IR_W - 1; gi++) begin : g_ir_shift
         assign ir_shift[gi] = ir_sr_q[gi+1];
      end
   endgenerate
   assign ir_shift[IR_W-1] = jtag.TDI;

   assign bsr_sel = (ir_q == EXTEST) || (ir_q == SAMPLE);

`ifdef JTAG_IDCODE_EN
   logic [31:0] id_sr_q, id_sr_d;

   assign id_sel = (ir_q == IDCODE);
   assign id_lsb = id_sr_q[0];

   always_comb begin
      id_sr_d = id_sr_q;
      if (state == CAP_DR)               id_sr_d = IDCODE_VAL;
      else if (state == SH_DR && id_sel) id_sr_d = {jtag.TDI, id_sr_q[31:1]};
   end

   always_ff @(posedge ICLK or posedge RST) begin
      if (RST) id_sr_q <= '0;
      else     id_sr_q <= id_sr_d;
   end
`else
   logic unused_idcode;
   assign unused_idcode = ^IDCODE_VAL;
   assign id_sel        = 1'b0;
   assign id_lsb        = 1'b0;
`endif

   always_comb begin
      ir_d     = ir_q;
      ir_sr_d  = ir_sr_q;
      bypass_d = bypass_q;
      case (state)
         CAP_IR:  ir_sr_d = IR_CAP;
         SH_IR:   ir_sr_d = ir_shift;
         UPD_IR:  ir_d    = ir_sr_q;
         CAP_DR:  bypass_d = 1'b0;
         SH_DR:   if (!bsr_sel && !id_sel) bypass_d = jtag.TDI;
         default: ;
      endcase
      // Reload on the edge that enters TLR so the reset instruction is live in TLR itself.
      if (state_next == TLR) ir_d = IR_RST;
   end

   always_ff @(posedge ICLK or posedge RST) begin
      if (RST) begin
         ir_q     <= IR_RST;
         ir_sr_q  <= '0;
         bypass_q <= 1'b0;
      end else begin
         ir_q     <= ir_d;
         ir_sr_q  <= ir_sr_d;
         bypass_q <= bypass_d;
      end
   end

   // Moore decode: the chain cells act on the same edge that leaves the state.
   always_comb begin
      jtag.mode      = (ir_q == EXTEST);
      jtag.shift_dr  = 1'b0;
      jtag.clk_dr    = 1'b0;
      jtag.update_dr = 1'b0;
      jtag.TDO       = 1'b0;
      jtag.TDO_EN    = 1'b0;
      case (state)
         CAP_DR: jtag.clk_dr = bsr_sel;
         SH_DR: begin
            jtag.shift_dr = bsr_sel;
            jtag.clk_dr   = bsr_sel;
            jtag.TDO_EN   = 1'b1;
            jtag.TDO      = bsr_sel ? jtag.bsr_tdo : (id_sel ? id_lsb : bypass_q);
         end
         UPD_DR: jtag.update_dr = bsr_sel;
         SH_IR: begin
            jtag.TDO_EN = 1'b1;
            jtag.TDO    = ir_sr_q[0];
         end
         default: ;
      endcase
   end

   assign jtag.bsr_tdi   = jtag.TDI;
   assign jtag.tap_state = state;

endmodule
